md_bank: RTL
============

Name: md_bank

Overview:
- Parametrised data memory for the MIPS datapath. Successor to the fixed 32x32 word memory.
- Byte-addressed, with configurable depth and byte/half/word access sizes. Narrow reads are sign- or zero-extended.
- Uses a req/ready/done handshake with a configurable number of wait states, so the pipeline can model slow memory.
- Sits between the core's MEM stage and its load/store unit.

Parameters:
- ADDR_W, 32, width of the byte address port.
- DEPTH_WORDS, 256, number of 32-bit words. Must be a power of two, at least 2.
- WAIT_CYCLES, 2, extra cycles between accept and response. Range 0..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  1  access request. Sampled only while ready=1.
- we  in  1  1 = store, 0 = load. Captured with req.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- sign_ext  in  1  load extension: 1 = sign, 0 = zero.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data. Low byte or low half is used for narrow stores.
- ready  out  1  block is idle and accepts a request this cycle.
- done  out  1  one-cycle pulse: access complete, rdata/err valid.
- rdata  out  32  extended load result. 0 for stores and errors.
- err  out  1  access rejected. Valid only with done.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE and the wait counter to 0.
  - done=0, err=0, rdata=0, ready=1 from the next cycle.
  - Memory array contents are not cleared.
- Reset mid-operation abandons the transaction: no write occurs, and no done is produced. Reset has priority over every other event at the same edge.
- FSM with states IDLE, BUSY and RESP.
  - IDLE:
    - ready=1.
    - On req=1, capture we, size, sign_ext, addr and wdata; load the counter with WAIT_CYCLES; go to BUSY.
  - BUSY:
    - ready=0. Inputs are ignored.
    - If the counter is nonzero, decrement it.
    - If the counter is 0, perform the access, register rdata/err, set done=1 and go to RESP.
  - RESP:
    - done=1 for exactly this cycle; ready=0.
    - The next edge goes to IDLE with done=0.
    - A req held high through RESP is not accepted until IDLE.
- Latency:
  - Request accepted at edge N.
  - done is high during the cycle after edge N+WAIT_CYCLES+1.
  - The next accept is possible no earlier than edge N+WAIT_CYCLES+3.
- Address decode:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Lane = addr[1:0].
  - Little-endian lanes: lane 0 maps to bits 7:0, lane 3 to bits 31:24.
- Error conditions: size=11, half access with addr[0]=1, or word access with addr[1:0]≠00.
  - The request still takes the full latency.
  - done=1, err=1, rdata=0, and memory is unmodified.
- Store:
  - Byte: writes wdata[7:0] into the addressed lane.
  - Half: writes wdata[15:0] into bits 15:0 (addr[1]=0) or 31:16 (addr[1]=1).
  - Word: writes all 32 bits.
  - Other lanes are preserved. rdata=0.
- Load:
  - Extract the lane and extend to 32 bits per sign_ext.
  - Word loads ignore sign_ext.
  - The read happens at the access edge, so it sees any store completed earlier.

Optional Feature:
- Macro: MD_BANK_BOUNDS_CHECK_EN.
- Defined: any addr bit above log2(DEPTH_WORDS)+1 set is an error. Response is err=1, rdata=0, no write, with normal latency.
- Undefined: the upper address bits are ignored and addresses alias modulo DEPTH_WORDS*4 bytes. err is raised only for size/alignment errors.

Test Plan (WAIT_CYCLES=2, DEPTH_WORDS=256):
- Word store then load: store 0xDEADBEEF at addr 0x14, then load word at 0x14 → rdata=0xDEADBEEF, err=0. done appears exactly 4 cycles after the accept cycle (WAIT_CYCLES+2). ready stays low between accept and RESP.
- Byte/half lanes: word 0x11223344 at 0x20, then store byte 0xAA at 0x22 → word reads 0x11AA3344.
  - lb at 0x22 with sign_ext=1 → 0xFFFFFFAA.
  - lb at 0x22 with sign_ext=0 → 0x000000AA.
  - lh at 0x22 with sign_ext=1 → 0x000011AA.
- Misalignment: store half at 0x21 and store word at 0x22 → err=1, rdata=0. A subsequent word read at 0x20 is unchanged.
- Reserved size: req with size=11 → done with err=1; no write.
- Reset mid-op: store word 0x12345678 to 0x30 (prior value 0), then pull rst_n low during BUSY → no done pulse, ready=1 after reset, and a word read at 0x30 returns 0.
- Bounds: store word to 0x400 then read 0x000.
  - With the macro defined → err=1 and 0x000 unchanged.
  - Without the macro → 0x000 returns the stored data (aliasing).

Source files
------------

// File: rtl/md_bank.sv
// md_bank: byte-addressed data memory for the MIPS datapath.
// Byte/half/word accesses, little-endian lanes, sign/zero-extended narrow loads,
// req/ready/done handshake with WAIT_CYCLES extra cycles of latency.
// Optional feature macro: MD_BANK_BOUNDS_CHECK_EN
//   defined   -> any address bit above the array range flags err
//   undefined -> upper address bits are ignored (addresses alias)
module md_bank #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg;
   logic              we_reg;
   logic [1:0]        size_reg;
   logic              sext_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic              done_reg;
   logic              err_reg;
   logic [31:0]       rdata_reg;

   logic [31:0]       mem [DEPTH_WORDS];

   logic              accept;
   logic              access;
   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        lane;
   logic              err_cond;
   logic [3:0]        be;
   logic [31:0]       wlane;
   logic [31:0]       rd_word;
   logic [31:0]       shifted;
   logic [31:0]       load_val;

   assign word_idx = addr_reg[IDX_W+1:2];
   assign lane     = addr_reg[1:0];

   // Next-state and handshake strobes
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      access     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt_reg == 4'd0) begin
               access     = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Wait-state counter: loaded on accept, counts down while BUSY
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_reg <= 4'd0;
      else if (accept)
         cnt_reg <= 4'(WAIT_CYCLES);
      else if (state_reg == BUSY && cnt_reg != 4'd0)
         cnt_reg <= cnt_reg - 4'd1;
   end

   // Request capture; later input changes are ignored until the next accept
   always_ff @(posedge clk) begin
      if (accept) begin
         we_reg    <= we;
         size_reg  <= size;
         sext_reg  <= sign_ext;
         addr_reg  <= addr;
         wdata_reg <= wdata;
      end
   end

`ifdef MD_BANK_BOUNDS_CHECK_EN
   logic out_of_range;
   assign out_of_range = |(addr_reg >> (IDX_W + 2));
`else
   logic unused_upper;
   assign unused_upper = ^(addr_reg >> (IDX_W + 2));
`endif

   // Rejection rules: reserved size, misaligned half/word, optional bounds
   always_comb begin
      err_cond = (size_reg == 2'b11) ||
                 (size_reg == 2'b01 && lane[0]) ||
                 (size_reg == 2'b10 && lane != 2'b00);
`ifdef MD_BANK_BOUNDS_CHECK_EN
      if (out_of_range) err_cond = 1'b1;
`endif
   end

   // Per-lane byte enable and replicated store data
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be[gi] = (size_reg == 2'b10) ||
                      (size_reg == 2'b01 && addr_reg[1] == 1'(gi / 2)) ||
                      (size_reg == 2'b00 && lane == 2'(gi));
      assign wlane[gi*8 +: 8] = (size_reg == 2'b00) ? wdata_reg[7:0] :
                                (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                      wdata_reg[8*gi +: 8];
   end

   // Memory write at the access edge, only for valid stores outside reset
   always_ff @(posedge clk) begin
      if (rst_n && access && we_reg && !err_cond) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][i*8 +: 8] <= wlane[i*8 +: 8];
         end
      end
   end

   // Lane extraction and extension of the addressed word
   always_comb begin
      rd_word  = mem[word_idx];
      shifted  = rd_word >> {lane, 3'b000};
      load_val = 32'd0;
      case (size_reg)
         2'b00:   load_val = {{24{sext_reg & shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = {{16{sext_reg & shifted[15]}}, shifted[15:0]};
         2'b10:   load_val = rd_word;
         default: load_val = 32'd0;
      endcase
   end

   // Response registers: one-cycle done pulse with rdata/err
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         rdata_reg <= 32'd0;
      end else if (access) begin
         done_reg  <= 1'b1;
         err_reg   <= err_cond;
         rdata_reg <= (err_cond || we_reg) ? 32'd0 : load_val;
      end else begin
         done_reg  <= 1'b0;
      end
   end

   assign ready = (state_reg == IDLE);
   assign done  = done_reg;
   assign err   = err_reg;
   assign rdata = rdata_reg;

endmodule
